// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and state encoding for the cache miss fill controller.
// The block geometry constants are also used by the cache data and tag arrays.
package cache_fill_fsm_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_BITS     = 4;
  localparam int ADDR_WIDTH      = 16;
  localparam int DATA_WIDTH      = 16;
  localparam int WORD_IDX_BITS   = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_WIDTH       = WORD_IDX_BITS + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Clear the byte-offset bits so the address points at the start of its block.
  function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
  endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Small up-counter used for the fill's request and return word counts.
// A synchronous clear takes priority over the count enable.
module fill_counter
  import cache_fill_fsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  // Count register: async reset, sync clear, then increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one block from pipelined main memory,
// streams each returned word into the data array, then writes the tag array.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [ADDR_WIDTH-1:0]    miss_address,
  input  logic                     memory_data_valid,
  input  logic [DATA_WIDTH-1:0]    memory_data,
  output logic                     fsm_busy,
  output logic                     memory_enable,
  output logic [ADDR_WIDTH-1:0]    memory_address,
  output logic                     write_data_array,
  output logic [WORD_IDX_BITS-1:0] data_word_offset,
  output logic [DATA_WIDTH-1:0]    fill_data,
  output logic                     write_tag_array,
  output logic [ADDR_WIDTH-1:0]    tag_address,
  output logic                     fill_done
);

  fill_state_t           state_r, state_next_s;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [CNT_WIDTH-1:0]  issue_cnt_s, recv_cnt_s;
  logic                  start_s, issue_en_s, recv_en_s;

  fill_counter u_issue_cnt (.clk(clk), .rst(rst), .clr(start_s), .en(issue_en_s), .count(issue_cnt_s));
  fill_counter u_recv_cnt  (.clk(clk), .rst(rst), .clr(start_s), .en(recv_en_s),  .count(recv_cnt_s));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Block base latched only when a miss is accepted from IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r <= '0;
    end else if (start_s) begin
      base_r <= block_base(miss_address);
    end
  end

  // Next-state and output decode; request and return sides advance independently
  always_comb begin
    state_next_s     = state_r;
    start_s          = 1'b0;
    issue_en_s       = 1'b0;
    recv_en_s        = 1'b0;
    fsm_busy         = 1'b0;
    memory_enable    = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_word_offset = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;
    tag_address      = '0;
    fill_done        = 1'b0;
    case (state_r)
      IDLE: begin
        fsm_busy = miss_detected;
        if (miss_detected) begin
          start_s      = 1'b1;
          state_next_s = FILL;
        end else begin
          state_next_s = IDLE;
        end
      end
      FILL: begin
        fsm_busy    = 1'b1;
        tag_address = base_r;
        if (issue_cnt_s < CNT_WIDTH'(WORDS_PER_BLOCK)) begin
          memory_enable  = 1'b1;
          memory_address = base_r + ADDR_WIDTH'({issue_cnt_s, 1'b0});
          issue_en_s     = 1'b1;
        end else begin
          memory_enable  = 1'b0;
          memory_address = '0;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_word_offset = recv_cnt_s[WORD_IDX_BITS-1:0];
          fill_data        = memory_data;
          recv_en_s        = 1'b1;
          if (recv_cnt_s == CNT_WIDTH'(WORDS_PER_BLOCK - 1)) begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            state_next_s    = IDLE;
          end else begin
            state_next_s = FILL;
          end
        end else begin
          state_next_s = FILL;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed-plus-random bench for cache_fill_fsm with a block-level memory model:
// memory returns the block's words in order, 4 cycles after each request, optionally delayed.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy, memory_enable, write_data_array, write_tag_array, fill_done;
  logic [15:0] memory_address, tag_address, fill_data;
  logic [2:0]  data_word_offset;

  int n_assert = 0;
  int n_fail   = 0;

  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .memory_enable(memory_enable), .memory_address(memory_address),
    .write_data_array(write_data_array), .data_word_offset(data_word_offset),
    .fill_data(fill_data), .write_tag_array(write_tag_array), .tag_address(tag_address),
    .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, fsm_busy, 0);
    chk({tag, "_men"}, memory_enable, 0);
    chk({tag, "_maddr"}, memory_address, 0);
    chk({tag, "_wda"}, write_data_array, 0);
    chk({tag, "_off"}, data_word_offset, 0);
    chk({tag, "_fdata"}, fill_data, 0);
    chk({tag, "_wta"}, write_tag_array, 0);
    chk({tag, "_tag"}, tag_address, 0);
    chk({tag, "_done"}, fill_done, 0);
  endtask

  // One idle cycle with no miss; spurious valids must be ignored.
  task automatic idle_cycle(input string tag);
    step();
    miss_detected     = 1'b0;
    miss_address      = 16'($urandom);
    memory_data_valid = 1'($urandom);
    memory_data       = 16'($urandom);
    #3;
    chk_all_zero(tag);
  endtask

  // Runs one fill; cycle 0 is the miss cycle. gap delays words 4..7.
  // rst_at >= 0 asserts reset in that cycle; hold keeps miss_detected high during the fill.
  task automatic run_fill(input string tag, input logic [15:0] addr, input int gap,
                          input int rst_at, input bit hold);
    logic [15:0] base;
    logic [15:0] wdata [8];
    int          due [8];
    int          k;
    int          busy_cycles;
    bit          finished;
    base        = {addr[15:4], 4'h0};
    k           = 0;
    busy_cycles = 0;
    finished    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wdata[i] = 16'($urandom);
      due[i]   = i + 5 + ((i >= 4) ? gap : 0);
    end
    for (int c = 0; c < 40 && !finished; c++) begin
      step();
      miss_detected = (c == 0) || hold;
      miss_address  = (c == 0) ? addr : 16'($urandom);
      if (k < 8 && due[k] == c) begin
        memory_data_valid = 1'b1;
        memory_data       = wdata[k];
      end else begin
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
      end
      if (c == rst_at) begin
        rst           = 1'b1;
        miss_detected = 1'b0;
        #3;
        chk_all_zero({tag, "_inrst"});
        if (memory_data_valid) k++;
        for (int t = c + 1; t < 16; t++) begin
          step();
          rst           = 1'b0;
          miss_detected = 1'b0;
          if (k < 8 && due[k] == t) begin
            memory_data_valid = 1'b1;
            memory_data       = wdata[k];
            k++;
          end else begin
            memory_data_valid = 1'b0;
          end
          #3;
          chk({tag, "_late_wda"}, write_data_array, 0);
          chk({tag, "_late_busy"}, fsm_busy, 0);
          chk({tag, "_late_done"}, fill_done, 0);
        end
        return;
      end
      #3;
      if (fsm_busy) busy_cycles++;
      chk({tag, "_busy"}, fsm_busy, 1);
      if (c == 0) begin
        chk({tag, "_c0_men"}, memory_enable, 0);
        chk({tag, "_c0_wda"}, write_data_array, 0);
        chk({tag, "_c0_tag"}, tag_address, 0);
      end else begin
        chk({tag, "_men"}, memory_enable, (c <= 8) ? 1 : 0);
        chk({tag, "_maddr"}, memory_address, (c <= 8) ? 16'(base + 16'(2 * (c - 1))) : 16'h0);
        chk({tag, "_tag"}, tag_address, base);
        chk({tag, "_wda"}, write_data_array, memory_data_valid);
        if (memory_data_valid) begin
          chk({tag, "_off"}, data_word_offset, k);
          chk({tag, "_fdata"}, fill_data, wdata[k]);
        end
        chk({tag, "_wta"}, write_tag_array, (memory_data_valid && k == 7) ? 1 : 0);
        chk({tag, "_done"}, fill_done, (memory_data_valid && k == 7) ? 1 : 0);
        if (memory_data_valid) begin
          if (k == 7) finished = 1'b1;
          k++;
        end
      end
    end
    chk({tag, "_completed"}, finished, 1);
    chk({tag, "_busy_len"}, busy_cycles, 13 + gap);
  endtask

  initial begin
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    repeat (2) @(posedge clk);
    #4;
    chk_all_zero("reset");
    step();
    rst = 1'b0;

    for (int i = 0; i < 3; i++) idle_cycle("idle_spurious");

    run_fill("basic", 16'h1236, 0, -1, 1'b0);
    idle_cycle("basic_after");

    run_fill("top", 16'hFFFB, 0, -1, 1'b0);
    idle_cycle("top_after");

    run_fill("gap", 16'($urandom), 2, -1, 1'b0);
    idle_cycle("gap_after");

    run_fill("rstmid", 16'($urandom), 0, 6, 1'b0);
    run_fill("post_rst", 16'h4000, 0, -1, 1'b0);
    idle_cycle("post_rst_after");

    run_fill("hold", 16'($urandom), 0, -1, 1'b1);
    run_fill("b2b", 16'($urandom), 0, -1, 1'b0);
    idle_cycle("b2b_after");

    for (int r = 0; r < 4; r++) begin
      run_fill("rand", 16'($urandom), int'($urandom_range(0, 3)), -1, 1'($urandom));
      idle_cycle("rand_after");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
